// File: rtl/ysyx_24080006_pkg.sv
// ysyx_24080006_pkg: shared fetch types, queue depth and RVC opcode test
package ysyx_24080006_pkg;
  localparam int HWQ_DEPTH = 4;
  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } fetch_hword_t;
  function automatic logic is_rvc(input logic [1:0] op);
    return op != 2'b11;
  endfunction
endpackage

// File: rtl/ysyx_24080006_fetch_align.sv
// ysyx_24080006_fetch_align: splits word-aligned fetch beats into 16/32-bit instructions with PC and fault flag
// Ports: clk_i/rst_ni clock and async active-low reset; flush_i/flush_pc_i restart;
// fetch_valid_i/fetch_ready_o/fetch_rdata_i/fetch_err_i fetch beat in;
// instr_valid_o/instr_ready_i/instr_o/instr_is_c_o/instr_pc_o/instr_err_o instruction out.
module ysyx_24080006_fetch_align
  import ysyx_24080006_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic        instr_is_c_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_err_o
);
  // Packed so the pop can be a plain right shift; entry 0 is the head.
  fetch_hword_t [HWQ_DEPTH-1:0] q_q, q_n;
  logic [2:0]  cnt_q, cnt_n, pop_n, push_n;
  logic [31:0] pc_q;
  logic        drop_q, head_c, push, pop;
  logic [1:0]  base;
  // A faulted head is reported alone as a 16-bit slot so the PC steps by 2.
  assign head_c        = q_q[0].err || is_rvc(q_q[0].data[1:0]);
  assign instr_valid_o = (cnt_q != 3'd0) && (head_c || cnt_q >= 3'd2);
  assign instr_is_c_o  = instr_valid_o && head_c;
  assign instr_o       = (!instr_valid_o || q_q[0].err) ? 32'h0 :
                         head_c ? {16'h0, q_q[0].data} : {q_q[1].data, q_q[0].data};
  assign instr_err_o   = instr_valid_o && (q_q[0].err || (!head_c && q_q[1].err));
  assign instr_pc_o    = pc_q;
  assign fetch_ready_o = cnt_q <= 3'd2;
  assign push          = fetch_valid_i && fetch_ready_o && !flush_i;
  assign pop           = instr_valid_o && instr_ready_i && !flush_i;
  assign pop_n         = !pop ? 3'd0 : head_c ? 3'd1 : 3'd2;
  assign push_n        = !push ? 3'd0 : drop_q ? 3'd1 : 3'd2;
  assign base          = 2'(cnt_q - pop_n);
  assign cnt_n         = cnt_q - pop_n + push_n;
  always_comb begin
    q_n = q_q >> ($bits(fetch_hword_t) * pop_n);
    if (push && drop_q) q_n[base] = '{data: fetch_rdata_i[31:16], err: fetch_err_i};
    else if (push) begin
      q_n[base]        = '{data: fetch_rdata_i[15:0], err: fetch_err_i};
      q_n[base + 2'd1] = '{data: fetch_rdata_i[31:16], err: fetch_err_i};
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q    <= '0;
      cnt_q  <= 3'd0;
      pc_q   <= RESET_PC;
      drop_q <= 1'b0;
    end else if (flush_i) begin
      cnt_q  <= 3'd0;
      pc_q   <= flush_pc_i & ~32'h1;
      drop_q <= flush_pc_i[1];
    end else begin
      q_q    <= q_n;
      cnt_q  <= cnt_n;
      pc_q   <= pc_q + 32'({pop_n, 1'b0});
      drop_q <= drop_q && !push;
    end
  end
endmodule

// File: tb/tb_ysyx_24080006_fetch_align.sv
// tb_ysyx_24080006_fetch_align: directed vector table plus random program streams against a memory-walk model
module tb_ysyx_24080006_fetch_align;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  logic        clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0, fetch_valid_i = 1'b0, fetch_err_i = 1'b0, instr_ready_i = 1'b0;
  logic [31:0] flush_pc_i = '0, fetch_rdata_i = '0;
  logic        fetch_ready_o, instr_valid_o, instr_is_c_o, instr_err_o;
  logic [31:0] instr_o, instr_pc_o;
  int nvec = 0, nerr = 0;
  ysyx_24080006_fetch_align #(.RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o), .fetch_rdata_i(fetch_rdata_i),
    .fetch_err_i(fetch_err_i), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_is_c_o(instr_is_c_o), .instr_pc_o(instr_pc_o), .instr_err_o(instr_err_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    bit fl; bit [31:0] fpc; bit fv; bit [31:0] fd; bit fe; bit ir;
    bit frdy; bit iv; bit [31:0] ins; bit isc; bit [31:0] pc; bit ierr;
  } vec_t;
  typedef struct { bit [31:0] ins; bit isc; bit [31:0] pc; bit err; } exp_t;
  vec_t tv[$];
  exp_t eq[$];
  exp_t e;
  logic [15:0] hw [64];
  logic        werr [32];
  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] x);
    nvec++;
    if (g !== x) begin
      nerr++;
      $display("FAIL %s: got %h want %h", n, g, x);
    end
  endtask
  initial begin
    int nw, off, p, wi, cyc;
    logic [31:0] base;
    logic [15:0] hv;
    //                fl  fpc           fv  fd            fe  ir    frdy iv  ins           isc pc            ierr
    tv.push_back('{'0, 32'h0,        '1, 32'h0001_4501, '0, '1,   '1, '0, 32'h0,        '0, 32'h8000_0000, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '1, '1, 32'h0000_4501, '1, 32'h8000_0000, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '1, '1, 32'h0000_0001, '1, 32'h8000_0002, '0});
    tv.push_back('{'0, 32'h0,        '1, 32'h0093_0001, '0, '1,   '1, '0, 32'h0,        '0, 32'h8000_0004, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '1, '1, 32'h0000_0001, '1, 32'h8000_0004, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '1, '0, 32'h0,        '0, 32'h8000_0006, '0});
    tv.push_back('{'0, 32'h0,        '1, 32'h0000_1000, '0, '1,   '1, '0, 32'h0,        '0, 32'h8000_0006, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '0, '1, 32'h1000_0093, '0, 32'h8000_0006, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '1, '1, 32'h0,        '1, 32'h8000_000A, '0});
    tv.push_back('{'1, 32'h8000_0106, '1, 32'hDEAD_BEEF, '0, '1,   '1, '0, 32'h0,        '0, 32'h8000_000C, '0});
    tv.push_back('{'0, 32'h0,        '1, 32'h8082_FFFF, '0, '1,   '1, '0, 32'h0,        '0, 32'h8000_0106, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '1, '1, 32'h0000_8082, '1, 32'h8000_0106, '0});
    tv.push_back('{'0, 32'h0,        '1, 32'h1234_5678, '1, '1,   '1, '0, 32'h0,        '0, 32'h8000_0108, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '1, '1, 32'h0,        '1, 32'h8000_0108, '1});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '1, '1, 32'h0,        '1, 32'h8000_010A, '1});
    tv.push_back('{'0, 32'h0,        '1, 32'h0013_0001, '0, '0,   '1, '0, 32'h0,        '0, 32'h8000_010C, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '1, '1, 32'h0000_0001, '1, 32'h8000_010C, '0});
    tv.push_back('{'0, 32'h0,        '1, 32'hAAAA_5555, '1, '1,   '1, '0, 32'h0,        '0, 32'h8000_010E, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '0, '1, 32'h5555_0013, '0, 32'h8000_010E, '1});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '1, '1, 32'h0,        '1, 32'h8000_0112, '1});
    tv.push_back('{'0, 32'h0,        '1, 32'h4505_4501, '0, '0,   '1, '0, 32'h0,        '0, 32'h8000_0114, '0});
    tv.push_back('{'0, 32'h0,        '1, 32'h450D_4509, '0, '0,   '1, '1, 32'h0000_4501, '1, 32'h8000_0114, '0});
    tv.push_back('{'0, 32'h0,        '1, 32'h4515_4511, '0, '0,   '0, '1, 32'h0000_4501, '1, 32'h8000_0114, '0});
    tv.push_back('{'0, 32'h0,        '1, 32'h4515_4511, '0, '0,   '0, '1, 32'h0000_4501, '1, 32'h8000_0114, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '0, '1, 32'h0000_4501, '1, 32'h8000_0114, '0});
    tv.push_back('{'0, 32'h0,        '1, 32'h4515_4511, '0, '1,   '0, '1, 32'h0000_4505, '1, 32'h8000_0116, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '1, '1, 32'h0000_4509, '1, 32'h8000_0118, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '1, '1, 32'h0000_450D, '1, 32'h8000_011A, '0});
    tv.push_back('{'0, 32'h0,        '1, 32'h4525_4521, '0, '1,   '1, '0, 32'h0,        '0, 32'h8000_011C, '0});
    tv.push_back('{'1, 32'h8000_0201, '1, 32'h1111_1111, '0, '1,   '1, '1, 32'h0000_4521, '1, 32'h8000_011C, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '1, '0, 32'h0,        '0, 32'h8000_0200, '0});
    tv.push_back('{'0, 32'h0,        '1, 32'h0001_0002, '0, '1,   '1, '0, 32'h0,        '0, 32'h8000_0200, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '1, '1, 32'h0000_0002, '1, 32'h8000_0200, '0});
    tv.push_back('{'1, 32'hFFFF_FFFE, '0, 32'h0,        '0, '1,   '1, '1, 32'h0000_0001, '1, 32'h8000_0202, '0});
    tv.push_back('{'0, 32'h0,        '1, 32'h0001_4501, '0, '1,   '1, '0, 32'h0,        '0, 32'hFFFF_FFFE, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '1, '1, 32'h0000_0001, '1, 32'hFFFF_FFFE, '0});
    tv.push_back('{'0, 32'h0,        '0, 32'h0,        '0, '1,   '1, '0, 32'h0,        '0, 32'h0000_0000, '0});
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    foreach (tv[k]) begin
      @(negedge clk_i);
      flush_i = tv[k].fl; flush_pc_i = tv[k].fpc; fetch_valid_i = tv[k].fv;
      fetch_rdata_i = tv[k].fd; fetch_err_i = tv[k].fe; instr_ready_i = tv[k].ir;
      #1;
      chk($sformatf("v%0d.ready", k), 32'(fetch_ready_o), 32'(tv[k].frdy));
      chk($sformatf("v%0d.valid", k), 32'(instr_valid_o), 32'(tv[k].iv));
      chk($sformatf("v%0d.instr", k), instr_o, tv[k].ins);
      chk($sformatf("v%0d.is_c", k), 32'(instr_is_c_o), 32'(tv[k].isc));
      chk($sformatf("v%0d.pc", k), instr_pc_o, tv[k].pc);
      chk($sformatf("v%0d.err", k), 32'(instr_err_o), 32'(tv[k].ierr));
    end
    // Random programs: the model walks a halfword memory from the start PC.
    for (int r = 0; r < 60; r++) begin
      nw = $urandom_range(4, 16);
      off = $urandom_range(0, 1);
      base = 32'h8000_1000 + 32'(r) * 32'h100;
      for (int w = 0; w < nw; w++) begin
        for (int j = 0; j < 2; j++) begin
          hv = 16'($urandom);
          if ($urandom_range(0, 1) == 1) hv[1:0] = 2'b11;
          else if (hv[1:0] == 2'b11) hv[1:0] = 2'b01;
          hw[2 * w + j] = hv;
        end
        werr[w] = $urandom_range(0, 7) == 0;
      end
      eq.delete();
      p = off;
      while (p < 2 * nw) begin
        if (werr[p / 2]) begin
          eq.push_back('{32'h0, '1, base + 32'(2 * p), '1}); p += 1;
        end else if (hw[p][1:0] != 2'b11) begin
          eq.push_back('{{16'h0, hw[p]}, '1, base + 32'(2 * p), '0}); p += 1;
        end else if (p + 1 < 2 * nw) begin
          eq.push_back('{{hw[p + 1], hw[p]}, '0, base + 32'(2 * p), werr[(p + 1) / 2]}); p += 2;
        end else break;
      end
      @(negedge clk_i);
      flush_i = 1'b1; flush_pc_i = base + 32'(2 * off);
      fetch_valid_i = 1'($urandom); instr_ready_i = 1'($urandom);
      wi = 0; cyc = 0;
      while ((wi < nw || eq.size() > 0) && cyc < 400) begin
        @(negedge clk_i);
        flush_i = 1'b0; cyc++;
        fetch_valid_i = wi < nw && $urandom_range(0, 3) != 0;
        fetch_rdata_i = {hw[2 * wi + 1], hw[2 * wi]};
        fetch_err_i = werr[wi];
        instr_ready_i = $urandom_range(0, 3) != 0;
        #1;
        if (instr_valid_o && instr_ready_i) begin
          if (eq.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL r%0d.extra: got instr %h pc %h want none", r, instr_o, instr_pc_o);
          end else begin
            e = eq.pop_front();
            chk($sformatf("r%0d.instr", r), instr_o, e.ins);
            chk($sformatf("r%0d.is_c", r), 32'(instr_is_c_o), 32'(e.isc));
            chk($sformatf("r%0d.pc", r), instr_pc_o, e.pc);
            chk($sformatf("r%0d.err", r), 32'(instr_err_o), 32'(e.err));
          end
        end
        if (fetch_valid_i && fetch_ready_o) wi++;
      end
      if (wi < nw || eq.size() > 0) begin
        nvec++; nerr++;
        $display("FAIL r%0d.timeout: got %0d beats/%0d left want %0d beats/0 left", r, wi, eq.size(), nw);
      end
    end
    // Asynchronous reset while holding buffered instructions.
    @(negedge clk_i);
    flush_i = 1'b0; fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0001_4501; instr_ready_i = 1'b0;
    @(posedge clk_i);
    #2;
    chk("arst.pre_valid", 32'(instr_valid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst.valid", 32'(instr_valid_o), 32'd0);
    chk("arst.pc", instr_pc_o, RESET_PC);
    chk("arst.ready", 32'(fetch_ready_o), 32'd1);
    chk("arst.instr", instr_o, 32'h0);
    @(negedge clk_i);
    fetch_valid_i = 1'b0;
    rst_ni = 1'b1;
    #1;
    chk("arst.post_valid", 32'(instr_valid_o), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
